clk_cntr_poller: RTL
====================

Name: clk_cntr_poller

Overview:
- Avalon-MM read master; the reading end of the clock-counter measurement slave.
- Periodically sweeps the per-channel frequency registers of that slave and checks each result against an expected window.
- Exposes per-channel pass flags for the board LEDs, plus a snapshot of the last values.
- Sits in the bring-up top level on the 125 MHz system clock, beside the measurement core in the qsys system.

Parameters:
NR_CHAN, 6, channels swept (1..8)
ADDR_W, 8, Avalon byte-address width
MEAS_OFFS, 4, word offset of channel 0 measurement register; channel i at byte address (MEAS_OFFS+i)*4
POLL_CYC, 125000000, clk cycles between sweep starts (>=2)
TIMEOUT_CYC, 256, max cycles from read accept to readdatavalid
EXP_MIN, 99900000, lower bound of valid count (unsigned, inclusive)
EXP_MAX, 100100000, upper bound of valid count (unsigned, inclusive)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
en  in  1  enables poll timer; sampled only in IDLE
avm_address  out  ADDR_W  byte address of current read
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data qualifier
chan_ok  out  NR_CHAN  per-channel result inside [EXP_MIN,EXP_MAX]
meas_flat  out  32*NR_CHAN  last captured value, channel i at bits [32*i+31:32*i]
sweep_done  out  1  one-cycle pulse at end of each sweep
timeout_err  out  1  sticky: some read timed out
busy  out  1  high while a sweep is in progress

Behaviour:
- Reset (async assert, sync release): state=IDLE; timer=POLL_CYC-1; chan index=0; avm_read=0; avm_address=0; chan_ok=0; meas_flat=0; sweep_done=0; timeout_err=0; busy=0.
- IDLE:
  - en=1: timer decrements each cycle. At timer==0 -> REQ; chan=0; timer reloads POLL_CYC-1.
  - en=0: timer holds.
  - First sweep begins POLL_CYC cycles after reset release with en held high.
- REQ: avm_read=1; avm_address=(MEAS_OFFS+chan)*4.
  - Both held stable while avm_waitrequest=1.
  - Transfer accepted on the cycle with avm_read=1 and avm_waitrequest=0 -> WAIT_RDV next cycle; avm_read deasserts that next cycle.
  - No timeout in REQ; the slave must eventually accept.
- WAIT_RDV: avm_read=0. Timeout counter starts at 0 on entry and increments each cycle.
  - readdatavalid=1: capture readdata into meas_flat[chan]; chan_ok[chan] = (EXP_MIN<=data && data<=EXP_MAX); -> NEXT.
  - Counter reaches TIMEOUT_CYC-1 without valid: chan_ok[chan]=0, meas_flat[chan] unchanged, timeout_err=1 -> NEXT.
  - readdatavalid on the same cycle the counter reaches TIMEOUT_CYC-1: data wins, no timeout.
- NEXT: chan==NR_CHAN-1 -> DONE; otherwise chan+1 -> REQ.
- DONE: sweep_done=1 for exactly this cycle; chan=0 -> IDLE.
- busy=1 in REQ, WAIT_RDV, NEXT and DONE.
- Only one read is outstanding at any time. readdatavalid outside WAIT_RDV, including late data after a timeout, is ignored with no state change.
- en deasserted mid-sweep: the sweep completes; en is only re-evaluated in IDLE.
- chan_ok bits update individually per channel as each result arrives; all other bits keep their previous sweep value.
- Read issue: back-to-back sweeps with no stall and immediate readdatavalid issue one read per 3 cycles (REQ, WAIT_RDV, NEXT).
- Reset mid-transfer: avm_read drops immediately (async). Pending readdatavalid after release is ignored, because the FSM is in IDLE.
- Comparison is 32-bit unsigned. Bounds are equal-inclusive: a value equal to EXP_MIN or EXP_MAX passes.

Test Plan:
- Nominal, NR_CHAN=6, POLL_CYC=100, slave zero-wait with 1-cycle readdatavalid, all values 100000000 -> reads at addresses 0x10,0x14,...,0x24 in order; chan_ok=6'b111111; sweep_done pulses once per 100-cycle period; timeout_err=0.
- Window edges: ch0=99900000, ch1=100100000, ch2=99899999, ch3=100100001, ch4=0, ch5=0xFFFFFFFF -> chan_ok=6'b000011; meas_flat holds all six values exactly.
- Stall: waitrequest=1 for 5 cycles on ch2 -> avm_address=0x18 and avm_read=1 held stable for all 6 cycles; one read only; result captured correctly.
- Timeout, TIMEOUT_CYC=16: ch3 never returns readdatavalid -> after 16 cycles, chan_ok[3]=0, timeout_err=1 sticky, sweep continues to ch4. A late valid at cycle 20 is ignored and ch4 is unaffected.
- en control: en=0 from reset for 500 cycles -> no reads issued. Raise en -> first read POLL_CYC cycles later. Drop en during ch1 read -> sweep finishes through ch5, sweep_done pulses, then no further sweeps.
- Async reset asserted while in WAIT_RDV on ch2 -> avm_read=0, busy=0, chan_ok=0, timeout_err=0 immediately; a stray readdatavalid after release produces no capture.

Source files
------------

// File: rtl/clk_cntr_poller.sv
// Avalon-MM read master that periodically sweeps the clock-counter measurement
// registers and flags each channel whose count falls inside [EXP_MIN, EXP_MAX].
module clk_cntr_poller #(
  parameter int          NR_CHAN     = 6,
  parameter int          ADDR_W      = 8,
  parameter int          MEAS_OFFS   = 4,
  parameter int          POLL_CYC    = 125000000,
  parameter int          TIMEOUT_CYC = 256,
  parameter logic [31:0] EXP_MIN     = 32'd99900000,
  parameter logic [31:0] EXP_MAX     = 32'd100100000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  output logic [ADDR_W-1:0]       avm_address_o,
  output logic                    avm_read_o,
  input  logic                    avm_waitrequest_i,
  input  logic [31:0]             avm_readdata_i,
  input  logic                    avm_readdatavalid_i,
  output logic [NR_CHAN-1:0]      chan_ok_o,
  output logic [32*NR_CHAN-1:0]   meas_flat_o,
  output logic                    sweep_done_o,
  output logic                    timeout_err_o,
  output logic                    busy_o
);

  localparam int TMR_W = $clog2(POLL_CYC);
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CH_W  = (NR_CHAN > 1) ? $clog2(NR_CHAN) : 1;

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NR_CHAN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RDV,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_err_q;
  logic              capture_stb;
  logic              timeout_stb;
  logic              in_window;
  logic [ADDR_W-1:0] req_addr;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      timer_q       <= TMR_RELOAD;
      chan_q        <= '0;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      chan_q   <= chan_d;
      to_cnt_q <= to_cnt_d;
      if (timeout_stb) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  // The timer keeps running through a sweep so sweep starts stay POLL_CYC apart;
  // only the IDLE countdown is gated by en.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    chan_d      = chan_q;
    to_cnt_d    = to_cnt_q;
    capture_stb = 1'b0;
    timeout_stb = 1'b0;
    if (state_q != S_IDLE && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (en_i) begin
          if (timer_q == '0) begin
            state_d = S_REQ;
            chan_d  = '0;
            timer_d = TMR_RELOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      S_REQ: begin
        if (!avm_waitrequest_i) begin
          state_d  = S_WAIT_RDV;
          to_cnt_d = '0;
        end
      end
      S_WAIT_RDV: begin
        if (avm_readdatavalid_i) begin
          capture_stb = 1'b1;
          state_d     = S_NEXT;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_stb = 1'b1;
          state_d     = S_NEXT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (chan_q == CH_LAST) begin
          state_d = S_DONE;
        end else begin
          chan_d  = chan_q + 1'b1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        chan_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_window = (avm_readdata_i >= EXP_MIN) && (avm_readdata_i <= EXP_MAX);
  assign req_addr  = (ADDR_W'(MEAS_OFFS) + ADDR_W'(chan_q)) << 2;

  assign avm_read_o    = (state_q == S_REQ);
  assign avm_address_o = (state_q == S_REQ) ? req_addr : '0;
  assign sweep_done_o  = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = timeout_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NR_CHAN; gi++) begin : g_chan
      logic [31:0] meas_q;
      logic        ok_q;
      logic        hit;

      assign hit = (chan_q == CH_W'(gi));

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          meas_q <= '0;
          ok_q   <= 1'b0;
        end else if (capture_stb && hit) begin
          meas_q <= avm_readdata_i;
          ok_q   <= in_window;
        end else if (timeout_stb && hit) begin
          ok_q <= 1'b0;
        end
      end

      assign meas_flat_o[32*gi +: 32] = meas_q;
      assign chan_ok_o[gi]            = ok_q;
    end
  endgenerate

endmodule
